// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the PC, reads instruction memory over a
// req/ack handshake and loads the IF/ID register whose opcode field feeds the
// control decoder. Handles hazard stalls, BNZ redirects and bubble injection.
// A bubble is always NOP_INSTR (opcode 6'b111111), so the decoder deasserts
// every write enable while IF/ID is invalid.
//
// Memory handshake: imem_req is high for the whole time a read is
// outstanding, and imem_addr stays fixed while it is high. The read completes
// on the clock edge where imem_ack=1; imem_rdata is only looked at on that
// edge. imem_ack is ignored while imem_req=0. A request, once raised, is never
// withdrawn: a redirect that arrives while it is outstanding is remembered in
// flush_pend_q and the returning word is thrown away.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   stall       hazard stall: hold IF/ID and stop advancing the PC
//   br_taken    one-cycle pulse: BNZ resolved taken
//   br_target   redirect address (bits [1:0] are forced to 0)
//   imem_req    read request
//   imem_addr   read address (= pc)
//   imem_ack    read complete, imem_rdata valid
//   imem_rdata  fetched word
//   if_instr    IF/ID instruction (NOP_INSTR when invalid)
//   if_opcode   if_instr[INSTR_W-1 -: 6], to the control decoder
//   if_pc4      address of if_instr + 4
//   if_valid    IF/ID holds a real instruction
//   dbg_state   current FSM state (S_IDLE=0, S_REQ=1, S_HOLD=2)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'hFC00_0000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [5:0]         if_opcode,
    output logic [ADDR_W-1:0]  if_pc4,
    output logic               if_valid,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_e               state_q,      state_d;
    logic [ADDR_W-1:0]    pc_q,         pc_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0]    tgt_q,        tgt_d;
    logic [INSTR_W-1:0]   hold_buf_q,   hold_buf_d;
    logic [ADDR_W-1:0]    hold_pc4_q,   hold_pc4_d;
    logic [INSTR_W-1:0]   if_instr_q,   if_instr_d;
    logic [ADDR_W-1:0]    if_pc4_q,     if_pc4_d;
    logic                 if_valid_q,   if_valid_d;

    logic [ADDR_W-1:0]    pc_inc;
    logic [ADDR_W-1:0]    br_tgt_al;

    // Unsigned modulo-2^ADDR_W increment; the wrap past the top is silent.
    assign pc_inc    = pc_q + PC_STEP;
    assign br_tgt_al = br_target & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            flush_pend_q <= 1'b0;
            tgt_q        <= '0;
            hold_buf_q   <= '0;
            hold_pc4_q   <= '0;
            if_instr_q   <= NOP_INSTR;
            if_pc4_q     <= '0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_pend_q <= flush_pend_d;
            tgt_q        <= tgt_d;
            hold_buf_q   <= hold_buf_d;
            hold_pc4_q   <= hold_pc4_d;
            if_instr_q   <= if_instr_d;
            if_pc4_q     <= if_pc4_d;
            if_valid_q   <= if_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_pend_d = flush_pend_q;
        tgt_d        = tgt_q;
        hold_buf_d   = hold_buf_q;
        hold_pc4_d   = hold_pc4_q;
        if_instr_d   = if_instr_q;
        if_pc4_d     = if_pc4_q;
        if_valid_d   = if_valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (imem_ack) begin
                    if (br_taken || flush_pend_q) begin
                        // Word belongs to the wrong path: drop it and
                        // re-request at the redirect address right away.
                        pc_d         = br_taken ? br_tgt_al : tgt_q;
                        flush_pend_d = 1'b0;
                        if_instr_d   = NOP_INSTR;
                        if_valid_d   = 1'b0;
                    end else if (stall) begin
                        // IF/ID is frozen, so park the word until the
                        // stall clears.
                        hold_buf_d = imem_rdata;
                        hold_pc4_d = pc_inc;
                        pc_d       = pc_inc;
                        state_d    = S_HOLD;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc4_d   = pc_inc;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc;
                    end
                end else begin
                    if (br_taken) begin
                        // The request cannot be withdrawn; remember the
                        // redirect and discard the word when it arrives.
                        flush_pend_d = 1'b1;
                        tgt_d        = br_tgt_al;
                        if_instr_d   = NOP_INSTR;
                        if_valid_d   = 1'b0;
                    end else if (!stall) begin
                        if_instr_d = NOP_INSTR;
                        if_valid_d = 1'b0;
                    end
                end
            end

            S_HOLD: begin
                if (br_taken) begin
                    pc_d       = br_tgt_al;
                    if_instr_d = NOP_INSTR;
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end else if (!stall) begin
                    if_instr_d = hold_buf_q;
                    if_pc4_d   = hold_pc4_q;
                    if_valid_d = 1'b1;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = if_instr_q[INSTR_W-1 -: 6];
    assign if_pc4    = if_pc4_q;
    assign if_valid  = if_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        req16, req8;
  logic [15:0] addr16;
  logic [7:0]  addr8;
  logic [31:0] instr16, instr8;
  logic [5:0]  op16, op8;
  logic [15:0] pc4_16;
  logic [7:0]  pc4_8;
  logic        valid16, valid8;
  logic [1:0]  state16, state8;

  instr_fetch_unit #(.ADDR_W(16)) dut16 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(req16), .imem_addr(addr16), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_instr(instr16), .if_opcode(op16), .if_pc4(pc4_16), .if_valid(valid16),
    .dbg_state(state16)
  );

  // Narrow-PC copy driven in lockstep; used to check modulo-256 wrap.
  instr_fetch_unit #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target[7:0]),
    .imem_req(req8), .imem_addr(addr8), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_instr(instr8), .if_opcode(op8), .if_pc4(pc4_8), .if_valid(valid8),
    .dbg_state(state8)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic        ack;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] tag(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction

  task automatic add(input logic s, input logic b, input logic [15:0] t, input logic a,
                     input logic er, input logic [15:0] ea, input logic ev,
                     input logic [15:0] ep, input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.ack = a;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc4 = ep; v.e_instr = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Memory model: on ack, return a word tagged with the address being read.
  task automatic drive(input logic s, input logic b, input logic [15:0] t, input logic a);
    stall      = s;
    br_taken   = b;
    br_target  = t;
    imem_ack   = a;
    imem_rdata = a ? tag(addr16) : 32'hDEAD_BEEF;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    chk({name, "_req"},    32'(req16),   32'h0);
    chk({name, "_addr"},   32'(addr16),  32'h0);
    chk({name, "_instr"},  instr16,      NOP);
    chk({name, "_opcode"}, 32'(op16),    32'h3F);
    chk({name, "_pc4"},    32'(pc4_16),  32'h0);
    chk({name, "_valid"},  32'(valid16), 32'h0);
    chk({name, "_state"},  32'(state16), 32'h0);
    chk({name, "_req8"},   32'(req8),    32'h0);
    chk({name, "_addr8"},  32'(addr8),   32'h0);
    chk({name, "_valid8"}, 32'(valid8),  32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ei;
    logic [15:0] ea;
    logic [15:0] ep;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (3) tick();
    check_reset("reset");

    //   stall br   tgt      ack  req  addr     valid pc4      instr
    // basic fetch, 1-cycle ack latency
    add(0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0004, 1, 16'h0004, tag(16'h0000));
    add(0, 0, 16'h0000, 1,   1, 16'h0008, 1, 16'h0008, tag(16'h0004));
    // stall coincident with ack at 8, held 3 cycles
    add(1, 0, 16'h0000, 1,   0, 16'h000C, 1, 16'h0008, tag(16'h0004));
    add(1, 0, 16'h0000, 0,   0, 16'h000C, 1, 16'h0008, tag(16'h0004));
    add(1, 0, 16'h0000, 0,   0, 16'h000C, 1, 16'h0008, tag(16'h0004));
    add(0, 0, 16'h0000, 0,   1, 16'h000C, 1, 16'h000C, tag(16'h0008));
    add(0, 0, 16'h0000, 1,   1, 16'h0010, 1, 16'h0010, tag(16'h000C));
    // waiting for memory, no stall -> bubble
    add(0, 0, 16'h0000, 0,   1, 16'h0010, 0, 16'h0010, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0014, 1, 16'h0014, tag(16'h0010));
    add(0, 0, 16'h0000, 1,   1, 16'h0018, 1, 16'h0018, tag(16'h0014));
    add(0, 0, 16'h0000, 1,   1, 16'h001C, 1, 16'h001C, tag(16'h0018));
    add(0, 0, 16'h0000, 1,   1, 16'h0020, 1, 16'h0020, tag(16'h001C));
    // branch while request to 0x20 waits 3 cycles; word@0x20 dropped
    add(0, 1, 16'h0043, 0,   1, 16'h0020, 0, 16'h0020, NOP);
    add(0, 0, 16'h0000, 0,   1, 16'h0020, 0, 16'h0020, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0040, 0, 16'h0020, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0044, 1, 16'h0044, tag(16'h0040));
    // second branch while a flush is pending overwrites the target
    add(0, 1, 16'h0100, 0,   1, 16'h0044, 0, 16'h0044, NOP);
    add(0, 1, 16'h0202, 0,   1, 16'h0044, 0, 16'h0044, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0200, 0, 16'h0044, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0204, 1, 16'h0204, tag(16'h0200));
    // branch + stall + ack on the same cycle: flush wins
    add(1, 1, 16'h0080, 1,   1, 16'h0080, 0, 16'h0204, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0084, 1, 16'h0084, tag(16'h0080));
    // stall with no ack leaves IF/ID alone
    add(1, 0, 16'h0000, 0,   1, 16'h0084, 1, 16'h0084, tag(16'h0080));
    // branch out of S_HOLD drops the held word
    add(1, 0, 16'h0000, 1,   0, 16'h0088, 1, 16'h0084, tag(16'h0080));
    add(1, 1, 16'h00C0, 0,   1, 16'h00C0, 0, 16'h0084, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h00C4, 1, 16'h00C4, tag(16'h00C0));
    // PC wrap: branch to the last word, fetch it, then address 0
    add(0, 1, 16'hFFFC, 0,   1, 16'h00C4, 0, 16'h00C4, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'hFFFC, 0, 16'h00C4, NOP);
    add(0, 0, 16'h0000, 1,   1, 16'h0000, 1, 16'h0000, tag(16'hFFFC));
    add(0, 0, 16'h0000, 1,   1, 16'h0004, 1, 16'h0004, tag(16'h0000));

    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].ack);
      tick();
      ei = vecs[i].e_instr;
      ea = vecs[i].e_addr;
      ep = vecs[i].e_pc4;
      chk($sformatf("v%0d_req", i),    32'(req16),   32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i),   32'(addr16),  32'(ea));
      chk($sformatf("v%0d_valid", i),  32'(valid16), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_pc4", i),    32'(pc4_16),  32'(ep));
      chk($sformatf("v%0d_instr", i),  instr16,      ei);
      chk($sformatf("v%0d_opcode", i), 32'(op16),    32'(ei[31:26]));
      chk($sformatf("v%0d_addr8", i),  32'(addr8),   32'(ea[7:0]));
      chk($sformatf("v%0d_pc4_8", i),  32'(pc4_8),   32'(ep[7:0]));
      chk($sformatf("v%0d_valid8", i), 32'(valid8),  32'(vecs[i].e_valid));
    end

    // Reset while a request is outstanding, with a late ack during reset.
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    check_reset("t6_rst");
    drive(1'b0, 1'b0, 16'h0, 1'b1);
    tick();
    check_reset("t6_late_ack");

    // Restart: first request in the 2nd cycle after release, from address 0.
    rst = 1'b0;
    exp_q.push_back(NOP);
    exp_q.push_back(tag(16'h0000));
    exp_q.push_back(tag(16'h0004));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 16'h0, k > 0);
      tick();
      chk($sformatf("t6_restart%0d_req", k),   32'(req16),  32'h1);
      chk($sformatf("t6_restart%0d_addr", k),  32'(addr16), 32'(k * 4));
      chk($sformatf("t6_restart%0d_pc4", k),   32'(pc4_16), 32'(k * 4));
      chk($sformatf("t6_restart%0d_instr", k), instr16,     exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
